alu_cmd_issuer: RTL

- Sequential front end for the 8-bit gate-level ALU.
- Accepts operation commands (A, B, Cin, S) over a valid/ready interface and buffers them in a small FIFO.
- Drives one command at a time onto the ALU inputs and waits a fixed settle time for the gate-level logic to propagate.
- Captures D/Z/Cout into a response register and returns the result over a valid/ready interface.
- Replaces open-loop timed stimulus with a handshaked, cycle-exact issuer usable by a controller or a self-checking bench.

---
 rtl/alu_cmd_issuer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// Handshaked command issuer for the gate-level ALU.
// Queues commands, holds ALU inputs for SETTLE cycles, returns captured results.
module alu_cmd_issuer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic                     cmd_cin,
  input  logic [3:0]               cmd_s,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_cin,
  output logic [3:0]               alu_s,
  input  logic [WIDTH-1:0]         alu_d,
  input  logic                     alu_z,
  input  logic                     alu_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_d,
  output logic                     rsp_z,
  output logic                     rsp_cout,
  output logic [3:0]               rsp_s,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE + 1);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [3:0]       s;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] cnt;
  state_t        state;
  logic          push;
  logic          pop;

  assign cmd_ready  = (count != (AW+1)'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == ST_IDLE) && (count != '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;
  assign busy       = (state != ST_IDLE) || (count != '0);

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: cmd_a, b: cmd_b,
                       cin: cmd_cin, s: cmd_s};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
      alu_s     <= '0;
      rsp_valid <= 1'b0;
      rsp_d     <= '0;
      rsp_z     <= 1'b0;
      rsp_cout  <= 1'b0;
      rsp_s     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            alu_a   <= head.a;
            alu_b   <= head.b;
            alu_cin <= head.cin;
            alu_s   <= head.s;
            cnt     <= CW'(SETTLE - 1);
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_d     <= alu_d;
            rsp_z     <= alu_z;
            rsp_cout  <= alu_cout;
            rsp_s     <= alu_s;
            rsp_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
